jpeg_chn_scheduler: RTL and testbench
=====================================

# jpeg_chn_scheduler

Sequencing controller for the time-multiplexed JPEG colour pipeline. It accepts one 8×8 RGB block per handshake and drives the shared DCT → quantize → zig-zag chain through Y, Cb and Cr in turn. It supplies the channel select for the DCT input mux and the quant-table mux, one-hot latch enables for the three zig-zag output registers, and a per-block completion pulse. A watchdog aborts a block if the DCT core never returns a result.

## Interface
- `ZZ_LAT`, 1: cycles from the `dct_out_valid` cycle to the zig-zag result being stable (0–7 legal).
- `TIMEOUT`, 255: maximum cycles spent in WAIT before abort (≥1).
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `blk_valid`  in  1  an RGB block is present and held stable until accepted.
- `blk_ready`  out  1  scheduler can accept a block; decoded as state==IDLE.
- `chn_sel`  out  2  active channel (0=Y, 1=Cb, 2=Cr); registered.
- `dct_in_valid`  out  1  DCT input strobe; decoded as state==ISSUE.
- `dct_in_ready`  in  1  DCT core accepts input.
- `dct_out_valid`  in  1  DCT result valid, one-cycle pulse.
- `latch_en`  out  3  one-hot write enable: bit0 Y, bit1 Cb, bit2 Cr; decoded as state==LATCH.
- `blk_done`  out  1  one-cycle pulse after the Cr latch.
- `busy`  out  1  state≠IDLE.
- `err_timeout`  out  1  sticky watchdog flag.
- `err_clr`  in  1  clears `err_timeout`.

## Operation
- States are IDLE, ISSUE, WAIT, DRAIN, LATCH and DONE.
- **IDLE:** on `blk_valid`&`blk_ready`, set `chn_sel`←0 and go to ISSUE.
- **ISSUE:** `dct_in_valid`=1. When `dct_in_ready`=1, go to WAIT and clear the watchdog. Otherwise hold indefinitely; the watchdog does not run in ISSUE.
- **WAIT:**
  - The watchdog increments each cycle.
  - When `dct_out_valid`=1, go to DRAIN and load drain_cnt←ZZ_LAT. If ZZ_LAT=0, go directly to LATCH.
  - Otherwise, when the watchdog reaches TIMEOUT: set `err_timeout`, set `chn_sel`←0, go to IDLE. No `latch_en` or `blk_done` is issued.
  - If `dct_out_valid` arrives on the same cycle the watchdog reaches TIMEOUT, the valid wins.
- **DRAIN:** decrement drain_cnt and go to LATCH when it reaches 1.
- **LATCH:** `latch_en`=1<<`chn_sel` for exactly one cycle. If `chn_sel`=2, go to DONE. Otherwise increment `chn_sel` and go to ISSUE.
- **DONE:** `blk_done`=1 for one cycle, then go to IDLE.
- `dct_out_valid` outside WAIT is ignored and causes no state change.
- `blk_valid` is ignored while busy; no new block is queued.
- `err_clr` clears `err_timeout`. A set on the same cycle as a clear wins.
- The watchdog counter width is $clog2(TIMEOUT+1) and it saturates; drain_cnt is 3 bits.
- **Reset values:** state IDLE, so `blk_ready`=1 and `busy`=0. `chn_sel`=0, `dct_in_valid`=0, `latch_en`=000, `blk_done`=0, `err_timeout`=0, all counters 0.
- **Reset mid-block:** abandons the block immediately with no `latch_en` and no `blk_done`.

## Timing
- Block accept edge is cycle 0. ISSUE(Y) is at cycle 1.
- With DCT latency L (`dct_out_valid` L cycles after the input handshake) and `dct_in_ready` held high, the per-channel period is L+ZZ_LAT+2 cycles.
- For L=17 and ZZ_LAT=1, a block runs as follows:
  - Y: ISSUE 1, WAIT 2–18, DRAIN 19, LATCH 20.
  - Cb: ISSUE 21, LATCH 40.
  - Cr: ISSUE 41, LATCH 60.
  - DONE at 61; `blk_ready` is high again at 62.
- Back-to-back throughput is one block per 3·(L+ZZ_LAT+2)+2 cycles.
- Decoded outputs (`blk_ready`, `dct_in_valid`, `latch_en`, `blk_done`, `busy`) change only on clk edges, because they derive only from registered state.
- Each DCT stall cycle in ISSUE adds exactly one cycle to the total latency.

## Test plan
- Reset release, `blk_valid` pulse, DCT model L=17 with `dct_in_ready`=1 → `latch_en`=001 at cycle 20, 010 at 40, 100 at 60. `blk_done` at 61, `blk_ready` at 62, `dct_in_valid` high on exactly 3 cycles.
- ZZ_LAT=0 and ZZ_LAT=3 builds → LATCH exactly ZZ_LAT+1 cycles after each `dct_out_valid`.
- `dct_in_ready` held low for 5 cycles during ISSUE(Cb) → Cb and Cr latches and `blk_done` each shift 5 cycles later; no timeout.
- DCT model never responds, TIMEOUT=255 → `err_timeout` rises 255 cycles into WAIT, scheduler returns to IDLE with `chn_sel`=0 and no `blk_done`. `err_clr` asserted the same cycle keeps `err_timeout`=1; `err_clr` the next cycle clears it.
- Spurious `dct_out_valid` in IDLE, plus `blk_valid` held high while busy → no state change, exactly one block processed. `reset_n` low during WAIT(Cb) → all outputs at reset values asynchronously; the next block starts at Y.

Source files
------------

// File: rtl/jpeg_chn_scheduler.sv
// Steps one RGB block through the shared DCT/quant/zig-zag chain as Y, Cb, Cr in turn,
// with a watchdog that abandons the block if the DCT never answers.
module jpeg_chn_scheduler #(
  parameter int ZZ_LAT  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       blk_valid,
  output logic       blk_ready,
  output logic [1:0] chn_sel,
  output logic       dct_in_valid,
  input  logic       dct_in_ready,
  input  logic       dct_out_valid,
  output logic [2:0] latch_en,
  output logic       blk_done,
  output logic       busy,
  output logic       err_timeout,
  input  logic       err_clr
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_LATCH,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      chn_nxt;
  logic [WD_W-1:0] wd_cnt, wd_nxt, wd_inc;
  logic [2:0]      drain_cnt, drain_nxt;
  logic            err_set;
  logic            err_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      chn_sel     <= 2'd0;
      wd_cnt      <= '0;
      drain_cnt   <= 3'd0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      chn_sel     <= chn_nxt;
      wd_cnt      <= wd_nxt;
      drain_cnt   <= drain_nxt;
      err_timeout <= err_nxt;
    end
  end

  // Watchdog saturates so a stuck value can never wrap back below the limit.
  assign wd_inc = (wd_cnt == {WD_W{1'b1}}) ? wd_cnt : wd_cnt + WD_W'(1);

  always_comb begin
    state_nxt = state;
    chn_nxt   = chn_sel;
    wd_nxt    = wd_cnt;
    drain_nxt = drain_cnt;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (blk_valid) begin
          chn_nxt   = 2'd0;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dct_in_ready) begin
          wd_nxt    = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_nxt = wd_inc;
        // A result arriving on the timeout cycle still counts as a result.
        if (dct_out_valid) begin
          if (ZZ_LAT == 0) begin
            state_nxt = S_LATCH;
          end else begin
            drain_nxt = 3'(ZZ_LAT);
            state_nxt = S_DRAIN;
          end
        end else if (wd_inc == WD_LIMIT) begin
          err_set   = 1'b1;
          chn_nxt   = 2'd0;
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_cnt != 3'd0) drain_nxt = drain_cnt - 3'd1;
        if (drain_cnt <= 3'd1) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        if (chn_sel == 2'd2) begin
          state_nxt = S_DONE;
        end else begin
          chn_nxt   = chn_sel + 2'd1;
          state_nxt = S_ISSUE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    err_nxt = err_set ? 1'b1 : (err_clr ? 1'b0 : err_timeout);
  end

  assign blk_ready    = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign dct_in_valid = (state == S_ISSUE);
  assign latch_en     = (state == S_LATCH) ? (3'b001 << chn_sel) : 3'b000;
  assign blk_done     = (state == S_DONE);

endmodule

// File: tb/tb_jpeg_chn_scheduler.sv
// Scoreboard bench: a main scheduler (ZZ_LAT=1) plus ZZ_LAT=0 and ZZ_LAT=3 builds,
// each fed by a fixed-latency DCT model.
module tb_jpeg_chn_scheduler;
  localparam int L = 17;

  typedef struct {
    int         cyc;
    logic [2:0] le;
    logic       done;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, rst_v_n;
  logic blk_valid, blk_valid_v, rdy0, spur, err_clr, mute;
  logic [2:0] mdl_v = 3'b000;
  int cyc = 0;

  logic [2:0] blk_ready, dct_in_valid, blk_done, busy, err_timeout;
  logic [1:0] chn_sel [3];
  logic [2:0] latch_en [3];

  int zz [3] = '{1, 0, 3};
  int rem [3] = '{0, 0, 0};
  int last_v [3] = '{0, 0, 0};
  int n_vec = 0;
  int n_miss = 0;
  int n_issue = 0;
  ev_t q0[$], q1[$], q2[$];

  jpeg_chn_scheduler #(.ZZ_LAT(1), .TIMEOUT(255)) u_dut (
    .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid), .blk_ready(blk_ready[0]),
    .chn_sel(chn_sel[0]), .dct_in_valid(dct_in_valid[0]), .dct_in_ready(rdy0),
    .dct_out_valid(mdl_v[0] | spur), .latch_en(latch_en[0]), .blk_done(blk_done[0]),
    .busy(busy[0]), .err_timeout(err_timeout[0]), .err_clr(err_clr));

  jpeg_chn_scheduler #(.ZZ_LAT(0), .TIMEOUT(255)) u_z0 (
    .clk(clk), .reset_n(rst_v_n), .blk_valid(blk_valid_v), .blk_ready(blk_ready[1]),
    .chn_sel(chn_sel[1]), .dct_in_valid(dct_in_valid[1]), .dct_in_ready(1'b1),
    .dct_out_valid(mdl_v[1]), .latch_en(latch_en[1]), .blk_done(blk_done[1]),
    .busy(busy[1]), .err_timeout(err_timeout[1]), .err_clr(1'b0));

  jpeg_chn_scheduler #(.ZZ_LAT(3), .TIMEOUT(255)) u_z3 (
    .clk(clk), .reset_n(rst_v_n), .blk_valid(blk_valid_v), .blk_ready(blk_ready[2]),
    .chn_sel(chn_sel[2]), .dct_in_valid(dct_in_valid[2]), .dct_in_ready(1'b1),
    .dct_out_valid(mdl_v[2]), .latch_en(latch_en[2]), .blk_done(blk_done[2]),
    .busy(busy[2]), .err_timeout(err_timeout[2]), .err_clr(1'b0));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input int c, input logic [2:0] le, input logic d);
    ev_t e;
    e.cyc = c; e.le = le; e.done = d;
    case (idx)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Hand-derived schedule: per-channel period L+ZZ_LAT+2, stall delays Cb onwards.
  task automatic expect_block(input int idx, input int c0, input int z, input int stall);
    int p;
    p = L + z + 2;
    push(idx, c0 + p, 3'b001, 1'b0);
    push(idx, c0 + 2*p + stall, 3'b010, 1'b0);
    push(idx, c0 + 3*p + stall, 3'b100, 1'b0);
    push(idx, c0 + 3*p + stall + 1, 3'b000, 1'b1);
  endtask

  task automatic check_ev(input int idx, input logic [2:0] le, input logic d);
    ev_t e;
    bit found;
    found = 1'b0;
    case (idx)
      0: if (q0.size() > 0) begin e = q0.pop_front(); found = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); found = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); found = 1'b1; end
    endcase
    n_vec++;
    if (!found) begin
      n_miss++;
      $display("FAIL unexpected_out[%0d]: cycle %0d latch_en=%b blk_done=%b, required no output",
               idx, cyc, le, d);
    end else if (e.cyc != cyc || e.le !== le || e.done !== d) begin
      n_miss++;
      $display("FAIL out[%0d]: got cycle %0d latch_en=%b blk_done=%b, required cycle %0d latch_en=%b blk_done=%b",
               idx, cyc, le, d, e.cyc, e.le, e.done);
    end
  endtask

  // Monitor first (sees last cycle's model output), then advance the DCT model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mdl_v[i]) last_v[i] = cyc - 1;
      if (latch_en[i] != 3'b000 || blk_done[i]) check_ev(i, latch_en[i], blk_done[i]);
      if (i > 0 && latch_en[i] != 3'b000)
        chk($sformatf("latch_delay_zz%0d", zz[i]), cyc - last_v[i], zz[i] + 1);
    end
    if (dct_in_valid[0]) n_issue++;
    for (int i = 0; i < 3; i++) begin
      logic rs, rd;
      rs = (i == 0) ? reset_n : rst_v_n;
      rd = (i == 0) ? rdy0 : 1'b1;
      if (!rs) begin
        rem[i] = 0;
        mdl_v[i] = 1'b0;
      end else begin
        mdl_v[i] = (rem[i] == 1) && !(i == 0 && mute);
        if (rem[i] > 0) rem[i]--;
        if (dct_in_valid[i] && rd) rem[i] = L;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_blk_ready"}, blk_ready[0], 1);
    chk({tag, "_busy"}, busy[0], 0);
    chk({tag, "_chn_sel"}, chn_sel[0], 0);
    chk({tag, "_dct_in_valid"}, dct_in_valid[0], 0);
    chk({tag, "_latch_en"}, latch_en[0], 0);
    chk({tag, "_blk_done"}, blk_done[0], 0);
    chk({tag, "_err_timeout"}, err_timeout[0], 0);
  endtask

  initial begin
    int c0, c1;
    reset_n = 1'b0; rst_v_n = 1'b0;
    blk_valid = 1'b0; blk_valid_v = 1'b0;
    rdy0 = 1'b1; spur = 1'b0; err_clr = 1'b0; mute = 1'b0;
    tick(3);
    chk_reset_vals("reset");
    reset_n = 1'b1; rst_v_n = 1'b1;
    tick(2);

    // Nominal block on all three builds.
    c0 = cyc;
    blk_valid = 1'b1; blk_valid_v = 1'b1;
    expect_block(0, c0, 1, 0);
    expect_block(1, c0, 0, 0);
    expect_block(2, c0, 3, 0);
    n_issue = 0;
    tick(1);
    blk_valid = 1'b0; blk_valid_v = 1'b0;
    wait_until(c0 + 62);
    chk("nominal_ready_at_62", blk_ready[0], 1);
    chk("nominal_issue_count", n_issue, 3);
    wait_until(c0 + 70);

    // DCT stalls ISSUE(Cb) for 5 cycles.
    c0 = cyc;
    blk_valid = 1'b1;
    expect_block(0, c0, 1, 5);
    tick(1);
    blk_valid = 1'b0;
    wait_until(c0 + 21);
    rdy0 = 1'b0;
    wait_until(c0 + 25);
    chk("stall_in_valid", dct_in_valid[0], 1);
    chk("stall_chn_sel", chn_sel[0], 1);
    wait_until(c0 + 26);
    rdy0 = 1'b1;
    wait_until(c0 + 67);
    chk("stall_ready", blk_ready[0], 1);
    chk("stall_no_timeout", err_timeout[0], 0);

    // DCT never answers: watchdog abort and sticky flag.
    c0 = cyc;
    mute = 1'b1;
    blk_valid = 1'b1;
    tick(1);
    blk_valid = 1'b0;
    wait_until(c0 + 256);
    chk("wd_before_limit_err", err_timeout[0], 0);
    chk("wd_before_limit_busy", busy[0], 1);
    err_clr = 1'b1;
    wait_until(c0 + 257);
    chk("wd_err_set_beats_clr", err_timeout[0], 1);
    chk("wd_back_to_idle", blk_ready[0], 1);
    chk("wd_chn_sel", chn_sel[0], 0);
    wait_until(c0 + 258);
    chk("wd_err_cleared", err_timeout[0], 0);
    err_clr = 1'b0;
    mute = 1'b0;
    tick(2);

    // Spurious result in IDLE, then blk_valid held through the whole block.
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    chk("spurious_ready", blk_ready[0], 1);
    chk("spurious_busy", busy[0], 0);
    c1 = cyc;
    blk_valid = 1'b1;
    expect_block(0, c1, 1, 0);
    wait_until(c1 + 62);
    blk_valid = 1'b0;
    wait_until(c1 + 66);
    chk("held_valid_single_block_ready", blk_ready[0], 1);
    chk("held_valid_single_block_busy", busy[0], 0);

    // Asynchronous reset during WAIT(Cb).
    c0 = cyc;
    blk_valid = 1'b1;
    push(0, c0 + 20, 3'b001, 1'b0);
    tick(1);
    blk_valid = 1'b0;
    wait_until(c0 + 25);
    chk("pre_reset_busy", busy[0], 1);
    chk("pre_reset_chn_sel", chn_sel[0], 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    wait_until(c0 + 27);
    reset_n = 1'b1;
    wait_until(c0 + 30);
    c1 = cyc;
    blk_valid = 1'b1;
    expect_block(0, c1, 1, 0);
    tick(1);
    blk_valid = 1'b0;
    wait_until(c1 + 70);

    chk("leftover_main", q0.size(), 0);
    chk("leftover_zz0", q1.size(), 0);
    chk("leftover_zz3", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
